// File: rtl/kbd_event_dispatcher.sv
// Buffers released-key scancodes in a small FIFO and dispatches digit keys as PWM
// duty updates and W/A/S/D as VGA cursor moves, each over valid/ready with a timeout.
module kbd_event_dispatcher #(
    parameter int ADDR_W    = 2,
    parameter int DUTY_STEP = 25,
    parameter int TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [7:0]        scancode,
    input  logic              flag,
    output logic              pwm_valid,
    output logic [7:0]        pwm_duty,
    input  logic              pwm_ready,
    output logic              vga_valid,
    output logic [1:0]        vga_dir,
    input  logic              vga_ready,
    output logic [ADDR_W:0]   fifo_level,
    output logic              overflow,
    output logic [7:0]        drop_cnt
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int TMR_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, DECODE, WAIT_PWM, WAIT_VGA} state_t;

    state_t              state;
    logic [7:0]          mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [7:0]          cur_code;
    logic [TMR_W-1:0]    timer;

    logic                fifo_full;
    logic                pop;
    logic                push;
    logic                lost;
    logic                timer_done;
    logic                dig_hit;
    logic [3:0]          dig_val;
    logic                dir_hit;
    logic [1:0]          dir_val;
    logic                fsm_drop;

    function automatic logic [4:0] digit_of(input logic [7:0] code);
        case (code)
            8'h45:   return {1'b1, 4'd0};
            8'h16:   return {1'b1, 4'd1};
            8'h1E:   return {1'b1, 4'd2};
            8'h26:   return {1'b1, 4'd3};
            8'h25:   return {1'b1, 4'd4};
            8'h2E:   return {1'b1, 4'd5};
            8'h36:   return {1'b1, 4'd6};
            8'h3D:   return {1'b1, 4'd7};
            8'h3E:   return {1'b1, 4'd8};
            8'h46:   return {1'b1, 4'd9};
            default: return 5'd0;
        endcase
    endfunction

    function automatic logic [2:0] dir_of(input logic [7:0] code);
        case (code)
            8'h1D:   return {1'b1, 2'd0};
            8'h1C:   return {1'b1, 2'd1};
            8'h1B:   return {1'b1, 2'd2};
            8'h23:   return {1'b1, 2'd3};
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [7:0] duty_of(input logic [3:0] d);
        int prod;
        prod = int'(d) * DUTY_STEP;
        return (prod > 255) ? 8'd255 : prod[7:0];
    endfunction

    function automatic logic [7:0] sat_add(input logic [7:0] cnt, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, cnt} + {7'd0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    // A full FIFO still accepts a write when the FSM pops in the same cycle.
    assign fifo_full  = (fifo_level == (ADDR_W+1)'(DEPTH));
    assign pop        = (state == IDLE) && (fifo_level != '0);
    assign push       = flag && (!fifo_full || pop);
    assign lost       = flag && !push;
    assign timer_done = (timer == TMR_W'(TIMEOUT - 1));

    assign {dig_hit, dig_val} = digit_of(cur_code);
    assign {dir_hit, dir_val} = dir_of(cur_code);

    assign fsm_drop = ((state == DECODE) && !dig_hit && !dir_hit) ||
                      ((state == WAIT_PWM) && !pwm_ready && timer_done) ||
                      ((state == WAIT_VGA) && !vga_ready && timer_done);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= scancode;
        if (pop)
            cur_code <= mem[rd_ptr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
            drop_cnt   <= 8'd0;
            pwm_valid  <= 1'b0;
            pwm_duty   <= 8'd0;
            vga_valid  <= 1'b0;
            vga_dir    <= 2'd0;
            timer      <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + ADDR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + ADDR_W'(1);
            if (push && !pop)
                fifo_level <= fifo_level + (ADDR_W+1)'(1);
            else if (pop && !push)
                fifo_level <= fifo_level - (ADDR_W+1)'(1);

            if (lost)
                overflow <= 1'b1;
            drop_cnt <= sat_add(drop_cnt, {1'b0, lost} + {1'b0, fsm_drop});

            case (state)
                IDLE: begin
                    if (pop)
                        state <= DECODE;
                end
                DECODE: begin
                    if (dig_hit) begin
                        pwm_duty  <= duty_of(dig_val);
                        pwm_valid <= 1'b1;
                        state     <= WAIT_PWM;
                    end else if (dir_hit) begin
                        vga_dir   <= dir_val;
                        vga_valid <= 1'b1;
                        state     <= WAIT_VGA;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT_PWM: begin
                    if (pwm_ready || timer_done) begin
                        pwm_valid <= 1'b0;
                        timer     <= '0;
                        state     <= IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                WAIT_VGA: begin
                    if (vga_ready || timer_done) begin
                        vga_valid <= 1'b0;
                        timer     <= '0;
                        state     <= IDLE;
                    end else begin
                        timer <= timer + TMR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_kbd_event_dispatcher.sv
// Two dispatcher instances (default timing, and short timeout with larger duty step)
// driven in lockstep and compared every cycle with a queue-based event model.
module tb_kbd_event_dispatcher;
    localparam int DEPTH = 4;

    logic       clk;
    logic       reset;
    logic [7:0] scancode;
    logic       flag;
    logic       pwm_ready;
    logic       vga_ready;
    logic [1:0] pwm_valid;
    logic [7:0] pwm_duty [2];
    logic [1:0] vga_valid;
    logic [1:0] vga_dir [2];
    logic [2:0] fifo_level [2];
    logic [1:0] overflow;
    logic [7:0] drop_cnt [2];

    int checks;
    int failures;

    kbd_event_dispatcher #(.ADDR_W(2), .DUTY_STEP(25), .TIMEOUT(1024)) dut_a (
        .clk(clk), .reset(reset), .scancode(scancode), .flag(flag),
        .pwm_valid(pwm_valid[0]), .pwm_duty(pwm_duty[0]), .pwm_ready(pwm_ready),
        .vga_valid(vga_valid[0]), .vga_dir(vga_dir[0]), .vga_ready(vga_ready),
        .fifo_level(fifo_level[0]), .overflow(overflow[0]), .drop_cnt(drop_cnt[0])
    );

    kbd_event_dispatcher #(.ADDR_W(2), .DUTY_STEP(30), .TIMEOUT(16)) dut_b (
        .clk(clk), .reset(reset), .scancode(scancode), .flag(flag),
        .pwm_valid(pwm_valid[1]), .pwm_duty(pwm_duty[1]), .pwm_ready(pwm_ready),
        .vga_valid(vga_valid[1]), .vga_dir(vga_dir[1]), .vga_ready(vga_ready),
        .fifo_level(fifo_level[1]), .overflow(overflow[1]), .drop_cnt(drop_cnt[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a queue of pending codes plus the event currently in hand.
    logic [7:0] dig_tab [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] dir_tab [4]  = '{8'h1D, 8'h1C, 8'h1B, 8'h23};
    int         m_step [2]   = '{25, 30};
    int         m_tmo  [2]   = '{1024, 16};

    logic [7:0] mq [2][$];
    int         phase [2];   // 0 waiting for an event, 1 event in hand, 2 offering
    int         age [2];     // cycles the current offer has been visible
    bit         is_pwm [2];
    logic [7:0] held [2];
    logic       e_pv [2];
    logic       e_vv [2];
    logic [7:0] e_duty [2];
    logic [1:0] e_dir [2];
    logic       e_ovf [2];
    int         e_drop [2];

    task automatic model_clear(input int k);
        mq[k].delete();
        phase[k]  = 0;
        age[k]    = 0;
        is_pwm[k] = 1'b0;
        held[k]   = 8'd0;
        e_pv[k]   = 1'b0;
        e_vv[k]   = 1'b0;
        e_duty[k] = 8'd0;
        e_dir[k]  = 2'd0;
        e_ovf[k]  = 1'b0;
        e_drop[k] = 0;
    endtask

    task automatic model_step();
        int lost, fdrop, d, dd;
        bit popped, full, rdy;
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                model_clear(k);
                continue;
            end
            lost = 0; fdrop = 0; popped = 1'b0;
            full = (mq[k].size() == DEPTH);
            if (phase[k] == 0) begin
                if (mq[k].size() > 0) begin
                    held[k]  = mq[k].pop_front();
                    popped   = 1'b1;
                    phase[k] = 1;
                end
            end else if (phase[k] == 1) begin
                d = -1; dd = -1;
                for (int i = 0; i < 10; i++) if (dig_tab[i] == held[k]) d = i;
                for (int i = 0; i < 4; i++) if (dir_tab[i] == held[k]) dd = i;
                if (d >= 0) begin
                    e_duty[k] = (d * m_step[k] > 255) ? 8'd255 : 8'(d * m_step[k]);
                    e_pv[k] = 1'b1; is_pwm[k] = 1'b1; phase[k] = 2; age[k] = 1;
                end else if (dd >= 0) begin
                    e_dir[k] = 2'(dd);
                    e_vv[k] = 1'b1; is_pwm[k] = 1'b0; phase[k] = 2; age[k] = 1;
                end else begin
                    fdrop = 1; phase[k] = 0;
                end
            end else begin
                rdy = is_pwm[k] ? pwm_ready : vga_ready;
                if (rdy || age[k] == m_tmo[k]) begin
                    if (!rdy) fdrop = 1;
                    e_pv[k] = 1'b0; e_vv[k] = 1'b0; phase[k] = 0;
                end else begin
                    age[k]++;
                end
            end
            if (flag) begin
                if (!full || popped) mq[k].push_back(scancode);
                else lost = 1;
            end
            if (lost != 0) e_ovf[k] = 1'b1;
            e_drop[k] = e_drop[k] + lost + fdrop;
            if (e_drop[k] > 255) e_drop[k] = 255;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("pwm_valid[%0d]", k), 32'(pwm_valid[k]), 32'(e_pv[k]));
            chk($sformatf("pwm_duty[%0d]", k), 32'(pwm_duty[k]), 32'(e_duty[k]));
            chk($sformatf("vga_valid[%0d]", k), 32'(vga_valid[k]), 32'(e_vv[k]));
            chk($sformatf("vga_dir[%0d]", k), 32'(vga_dir[k]), 32'(e_dir[k]));
            chk($sformatf("fifo_level[%0d]", k), 32'(fifo_level[k]), 32'(mq[k].size()));
            chk($sformatf("overflow[%0d]", k), 32'(overflow[k]), 32'(e_ovf[k]));
            chk($sformatf("drop_cnt[%0d]", k), 32'(drop_cnt[k]), 32'(e_drop[k]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic send(input logic [7:0] code);
        scancode = code;
        flag     = 1'b1;
        tick();
        flag     = 1'b0;
    endtask

    // Called just after an edge: asserts reset mid-cycle, checks the asynchronous
    // clear, then releases it away from the clock edge.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_pwm_valid[%0d]", k), 32'(pwm_valid[k]), 32'd0);
            chk($sformatf("rst_pwm_duty[%0d]", k), 32'(pwm_duty[k]), 32'd0);
            chk($sformatf("rst_vga_valid[%0d]", k), 32'(vga_valid[k]), 32'd0);
            chk($sformatf("rst_vga_dir[%0d]", k), 32'(vga_dir[k]), 32'd0);
            chk($sformatf("rst_fifo_level[%0d]", k), 32'(fifo_level[k]), 32'd0);
            chk($sformatf("rst_overflow[%0d]", k), 32'(overflow[k]), 32'd0);
            chk($sformatf("rst_drop_cnt[%0d]", k), 32'(drop_cnt[k]), 32'd0);
        end
        tick();
        tick();
        #3 reset = 1'b0;
    endtask

    int d0;
    int r;
    bit hold_mode;

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1; flag = 1'b0; scancode = 8'd0; pwm_ready = 1'b0; vga_ready = 1'b0;
        model_clear(0); model_clear(1);
        tick();
        do_reset();

        // Digit 7 with ready already high: offered for exactly cycle 3.
        pwm_ready = 1'b1; vga_ready = 1'b1;
        send(8'h3D);
        chk("lat_level_c1", 32'(fifo_level[0]), 32'd1);
        tick();
        chk("lat_valid_c2", 32'(pwm_valid[0]), 32'd0);
        tick();
        chk("digit7_valid", 32'(pwm_valid[0]), 32'd1);
        chk("digit7_duty25", 32'(pwm_duty[0]), 32'd175);
        chk("digit7_duty30", 32'(pwm_duty[1]), 32'd210);
        tick();
        chk("digit7_drop_valid", 32'(pwm_valid[0]), 32'd0);
        chk("digit7_no_vga", 32'(vga_valid[0]), 32'd0);

        // Digit 9: saturates with step 30.
        send(8'h46);
        tick(); tick();
        chk("digit9_duty30_sat", 32'(pwm_duty[1]), 32'd255);
        chk("digit9_duty25", 32'(pwm_duty[0]), 32'd225);
        tick();

        // 'A': held for 10 cycles until vga_ready rises.
        pwm_ready = 1'b0; vga_ready = 1'b0;
        send(8'h1C);
        tick(); tick();
        chk("vga_a_valid", 32'(vga_valid[0]), 32'd1);
        chk("vga_a_dir", 32'(vga_dir[0]), 32'd1);
        repeat (10) tick();
        chk("vga_a_held", 32'(vga_valid[1]), 32'd1);
        vga_ready = 1'b1;
        tick();
        chk("vga_a_released", 32'(vga_valid[0]), 32'd0);
        vga_ready = 1'b0;

        // Unknown code is dropped after decode.
        send(8'h5A);
        tick(); tick();
        chk("unknown_drop", 32'(drop_cnt[0]), 32'd1);
        chk("unknown_no_pwm", 32'(pwm_valid[0]), 32'd0);
        chk("unknown_no_vga", 32'(vga_valid[0]), 32'd0);

        // Overflow: six digits four cycles apart with both consumers stalled.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send(dig_tab[i + 1]);
            if (i < 5) repeat (3) tick();
        end
        chk("ovf_level", 32'(fifo_level[0]), 32'd4);
        chk("ovf_sticky", 32'(overflow[0]), 32'd1);
        chk("ovf_drop", 32'(drop_cnt[0]), 32'd1);
        chk("ovf_first_offered", 32'(pwm_valid[0]), 32'd1);
        pwm_ready = 1'b1;
        repeat (20) tick();

        // Timeout on the short-timeout instance, with a second event queued behind.
        pwm_ready = 1'b0;
        d0 = e_drop[1];
        send(dig_tab[2]);
        send(dig_tab[3]);
        tick();
        chk("tmo_first_cycle", 32'(pwm_valid[1]), 32'd1);
        repeat (15) tick();
        chk("tmo_last_cycle", 32'(pwm_valid[1]), 32'd1);
        tick();
        chk("tmo_dropped", 32'(pwm_valid[1]), 32'd0);
        chk("tmo_drop_cnt", 32'(drop_cnt[1]), 32'(d0 + 1));
        tick(); tick();
        chk("tmo_next_offer", 32'(pwm_valid[1]), 32'd1);
        pwm_ready = 1'b1;
        repeat (12) tick();

        // Reset while a cursor move is offered and three codes are buffered.
        pwm_ready = 1'b0; vga_ready = 1'b0;
        send(8'h1D); send(8'h1C); send(8'h1B); send(8'h23);
        tick();
        chk("rst_pre_vga", 32'(vga_valid[0]), 32'd1);
        chk("rst_pre_level", 32'(fifo_level[0]), 32'd3);
        do_reset();
        repeat (8) tick();
        chk("rst_post_vga", 32'(vga_valid[0]), 32'd0);
        chk("rst_post_level", 32'(fifo_level[0]), 32'd0);

        // Randomized traffic with alternating stall windows.
        for (int c = 0; c < 800; c++) begin
            if (c % 40 == 0) hold_mode = ($urandom_range(0, 2) == 0);
            r = $urandom_range(0, 9);
            if (r < 4)      scancode = dig_tab[$urandom_range(0, 9)];
            else if (r < 7) scancode = dir_tab[$urandom_range(0, 3)];
            else            scancode = 8'($urandom);
            flag      = ($urandom_range(0, 2) == 0);
            pwm_ready = hold_mode ? 1'b0 : 1'($urandom_range(0, 1));
            vga_ready = hold_mode ? 1'b0 : 1'($urandom_range(0, 1));
            tick();
        end

        // Flood with unknown codes until the drop counter saturates.
        pwm_ready = 1'b0; vga_ready = 1'b0;
        scancode = 8'h5A; flag = 1'b1;
        repeat (300) tick();
        flag = 1'b0;
        chk("drop_sat_a", 32'(drop_cnt[0]), 32'd255);
        chk("drop_sat_b", 32'(drop_cnt[1]), 32'd255);
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/kbd_event_dispatcher.md
# kbd_event_dispatcher

Sequences key-release events from the PS/2 keyboard receiver (8-bit `scancode` plus one-cycle `flag`) into the rest of the design. Events are buffered in a small FIFO and decoded. Digit keys become PWM duty updates and W/A/S/D become VGA cursor moves, each delivered to its consumer over a valid/ready handshake with a timeout. Unrecognised codes, FIFO overflows and timeouts are counted.

## Interface
- `ADDR_W`, 2: FIFO address width; depth = 2**ADDR_W.
- `DUTY_STEP`, 25: PWM duty increment per digit value.
- `TIMEOUT`, 1024: cycles a consumer may hold off `ready` before the event is dropped (≥2).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `scancode`  in  8  released-key code from the receiver.
- `flag`  in  1  one-cycle strobe; `scancode` is valid this cycle.
- `pwm_valid`  out  1  duty update offered.
- `pwm_duty`  out  8  duty value; stable while `pwm_valid`.
- `pwm_ready`  in  1  PWM consumer accepts.
- `vga_valid`  out  1  cursor move offered.
- `vga_dir`  out  2  0=up(W 0x1D), 1=left(A 0x1C), 2=down(S 0x1B), 3=right(D 0x23).
- `vga_ready`  in  1  VGA consumer accepts.
- `fifo_level`  out  ADDR_W+1  current FIFO occupancy.
- `overflow`  out  1  sticky; set on any event lost because the FIFO was full.
- `drop_cnt`  out  8  saturating count of dropped events.

## Operation
- FIFO write:
  - On `flag`, if the FIFO is not full, or it is full but a pop occurs the same cycle, `scancode` is written.
  - Otherwise the event is lost, `overflow` is set, and `drop_cnt` is incremented.
- FSM states: IDLE, DECODE, WAIT_PWM, WAIT_VGA.
- IDLE: if the FIFO is non-empty, pop the head into `cur_code` and go to DECODE. Otherwise stay.
- DECODE, digit codes 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46 map to d=0..9:
  - `pwm_duty` = min(d*DUTY_STEP, 255).
  - `pwm_valid`=1, go to WAIT_PWM.
- DECODE, W/A/S/D: load `vga_dir`, set `vga_valid`=1, go to WAIT_VGA.
- DECODE, any other code: increment `drop_cnt`, go to IDLE.
- WAIT_x, transfer cycle (`x_valid` & `x_ready`): clear `x_valid`, clear the timer, go to IDLE.
- WAIT_x, no transfer: the timer increments. When it reaches TIMEOUT-1 without transfer, clear `x_valid`, increment `drop_cnt`, clear the timer, go to IDLE.
- Offer rules:
  - Only one of `pwm_valid`/`vga_valid` is high at any time.
  - Data does not change while valid is high.
  - Valid is never withdrawn except on a transfer or a timeout.
- `drop_cnt` arithmetic:
  - In one cycle it adds (overflow-loss ? 1:0) + (FSM drop ? 1:0).
  - The result saturates at 255 and never wraps.
- `overflow` clears only on reset.

## Timing
- All outputs are registered.
- Reset values: `pwm_valid`=0, `pwm_duty`=0, `vga_valid`=0, `vga_dir`=0, `fifo_level`=0, `overflow`=0, `drop_cnt`=0. FSM=IDLE, FIFO empty, timer=0.
- Reset is asynchronous. Asserting it mid-handshake drops valid immediately and discards FIFO contents.
- Latency with an empty FIFO and idle FSM:
  - `flag` is high in cycle 0.
  - The FIFO is written at edge 1 (`fifo_level`=1 in cycle 1).
  - The pop happens at edge 2.
  - Valid is high from cycle 3.
- Throughput: at most one event per 3 cycles (IDLE, DECODE, WAIT with ready=1 in the first WAIT cycle).
- `ready` is sampled only while valid is high. A `ready` held high early does not shorten latency below 3 cycles.
- A timeout drops valid after exactly TIMEOUT cycles of valid high without a transfer.
- Write and pop in the same cycle: `fifo_level` is unchanged. The pointers wrap modulo 2**ADDR_W.

## Test plan
- Digit path: flag with 0x3D (digit 7), `pwm_ready`=1 -> `pwm_valid` high in cycle 3 only, with `pwm_duty`=175. `vga_valid` stays 0.
- Saturation and VGA path:
  - 0x46 (digit 9) with DUTY_STEP=30 -> `pwm_duty`=255.
  - 0x1C -> `vga_dir`=1. `vga_valid` is held until `vga_ready` rises 10 cycles later, then drops the next cycle.
- Unknown code: flag 0x5A -> no valid on either port, `drop_cnt`=1 after DECODE.
- Overflow: both ready low, 6 flags 4 cycles apart -> the first event is offered, four events buffer (`fifo_level`=4), the 6th is lost. `overflow`=1, `drop_cnt`=1.
- Timeout: TIMEOUT=16, `pwm_ready` held 0 -> `pwm_valid` high exactly 16 cycles, then 0. `drop_cnt` increments. The next buffered event is offered 3 cycles later.
- Reset mid-WAIT_VGA with 3 entries buffered -> all outputs return to reset values asynchronously. No event is offered after release until a new flag.
